// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: arbiter states,
// datapath widths and the default starvation limit.
package reg_wb_arbiter_pkg;

    localparam int REG_ADDR_W           = 5;
    localparam int DATA_W               = 32;
    localparam int WAIT_W               = 2;
    localparam int STARVE_LIMIT_DEFAULT = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HELD   = 2'd1,
        ARB_STARVE = 2'd2
    } arb_state_e;

    // x0 is hardwired to zero, so a write aimed at it is never a real write.
    function automatic logic is_real_rd(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding register for a MUL/DIV result waiting for a free
// register-file write slot.
module wb_hold_buf
    import reg_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [REG_ADDR_W-1:0] load_rd,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  valid,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [DATA_W-1:0]     data
);

    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            rd_d    = load_rd;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign rd    = rd_q;
    assign data  = data_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the single register-file write port between the main pipeline
// (absolute priority) and a MUL/DIV unit whose result waits in a 1-entry buffer.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0]     pipe_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wd,
    output logic                  held_valid,
    output logic [REG_ADDR_W-1:0] held_rd,
    output logic                  stall_req
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]     rf_wd_q, rf_wd_d;

    logic                  pipe_write;
    logic                  md_accept;
    logic                  buf_load;
    logic                  buf_clear;
    logic                  buf_valid;
    logic [REG_ADDR_W-1:0] buf_rd;
    logic [DATA_W-1:0]     buf_data;

    wb_hold_buf u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_rd   (md_rd),
        .load_data (md_data),
        .valid     (buf_valid),
        .rd        (buf_rd),
        .data      (buf_data)
    );

    // Gated by reset so no handshake can be seen while the block is held in reset.
    assign md_ready   = rst && (state_q == ARB_IDLE);
    assign md_accept  = md_valid && md_ready;
    assign pipe_write = pipe_valid && is_real_rd(pipe_rd);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wd_d    = rf_wd_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        if (pipe_write) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_rd;
            rf_wd_d    = pipe_data;
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (md_accept && is_real_rd(md_rd)) begin
                    buf_load   = 1'b1;
                    state_d    = ARB_HELD;
                    wait_cnt_d = '0;
                end
            end
            ARB_HELD, ARB_STARVE: begin
                if (!pipe_write) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = buf_rd;
                    rf_wd_d    = buf_data;
                    buf_clear  = 1'b1;
                    state_d    = ARB_IDLE;
                    wait_cnt_d = '0;
                end else if (state_q == ARB_HELD) begin
                    // In HELD the count is below LIMIT, so +1 cannot overflow.
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == LIMIT) begin
                        state_d = ARB_STARVE;
                    end
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wd_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wd_q    <= rf_wd_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wd      = rf_wd_q;
    assign held_valid = buf_valid;
    assign held_rd    = buf_valid ? buf_rd : '0;
    assign stall_req  = (state_q == ARB_STARVE);

endmodule
